spike_step_scheduler: RTL and testbench
=======================================

Name: spike_step_scheduler

Overview:
Timestep sequencer for the LIF/Izhikevich neuron accelerator array. It buffers arriving spike packets in a FIFO and issues the per-timestep clear pulse. During a fixed accumulate window it broadcasts one buffered source address per cycle to all neurons. After the accelerator pipeline settles, it samples the neuron spike vector and serialises fired neurons into outgoing spike packets for the NoC router.

Parameters:
NEURONS, 10, neurons served by the attached accelerator
ADDR_W, 12, spike/neuron address width
FIFO_DEPTH, 8, inbound packet FIFO entries (power of 2)
ACCUM_CYCLES, 8, cycles per timestep in which source addresses are broadcast
SETTLE_CYCLES, 4, cycles waited after ACCUM before sampling neuron_spike
IDLE_ADDR, 12'hFFF, value driven on src_addr when no address is presented

Ports:
CLK  in  1  clock, all logic on posedge
RESETN  in  1  synchronous active-low reset
enable  in  1  run timesteps; sampled in IDLE and at end of EMIT
in_valid  in  1  inbound spike packet valid
in_ready  out  1  FIFO can accept
in_addr  in  ADDR_W  origin neuron address of inbound packet
src_valid  out  1  src_addr carries a live address this cycle
src_addr  out  ADDR_W  broadcast source address to all neurons
clear  out  1  one-cycle timestep-start pulse to accelerator
neuron_spike  in  NEURONS  spike vector from accelerator
neuron_base  in  ADDR_W  address of local neuron 0
out_valid  out  1  outbound spike packet valid
out_ready  in  1  router accepts outbound packet
out_addr  out  ADDR_W  address of fired local neuron
timestep  out  16  completed-timestep counter, wraps at 16'hFFFF->0
busy  out  1  state != IDLE

Behaviour:
- Clock CLK; reset RESETN synchronous, active-low.
- Reset: state=IDLE, FIFO emptied, in_ready=0 while RESETN=0, src_valid=0, src_addr=IDLE_ADDR, clear=0, out_valid=0, out_addr=0, timestep=0, busy=0. Reset mid-operation discards FIFO contents and the latched spike vector.
- in_ready = !full (registered count), independent of state. A push occurs on in_valid&&in_ready. A push when full is blocked even if a pop occurs in the same cycle. Simultaneous push and pop with count<FIFO_DEPTH leaves count unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
- States: IDLE, CLEAR, ACCUM, SETTLE, EMIT. All outputs registered.
- IDLE: enable=1 -> CLEAR.
- CLEAR: clear=1 for exactly one cycle -> ACCUM. Phase counter is zeroed.
- ACCUM: lasts exactly ACCUM_CYCLES cycles. In each cycle with FIFO non-empty, pop the head, drive src_addr=head, src_valid=1. If FIFO is empty, src_valid=0 and src_addr=IDLE_ADDR. At most one pop per cycle. Entries left at the end of the window carry into the next timestep in order. Then -> SETTLE.
- SETTLE: src_valid=0. Wait SETTLE_CYCLES cycles. On the last cycle, latch neuron_spike into spike_reg. Next state is EMIT if spike_reg!=0, else end-of-step.
- EMIT: present the lowest set bit i of spike_reg: out_valid=1, out_addr=neuron_base+i (modulo 2^ADDR_W). out_addr is held stable until out_valid&&out_ready. On accept, clear bit i; the next bit is presented the following cycle. When spike_reg==0 -> end-of-step.
- End-of-step: timestep+1. Next state is CLEAR if enable=1, else IDLE.
- Step latency without spikes: 1+ACCUM_CYCLES+SETTLE_CYCLES cycles, i.e. clear period 13 cycles at defaults.
- Deasserting enable mid-step completes the current step (including EMIT) before IDLE.
- neuron_spike is ignored outside the sampling cycle.

Optional Feature:
STEP_STATS_EN. When defined, adds outputs stat_spikes_out (16 bit) and stat_carry (8 bit). stat_spikes_out counts accepted outbound packets, saturating at 16'hFFFF. stat_carry is loaded with the FIFO count at the end of each ACCUM. Both reset to 0. When undefined, these ports and their logic are absent and the remaining behaviour is identical.

Test Plan:
- Reset then enable=1, no input -> clear pulses at cycles 1,14,27; src_valid stays 0; timestep increments at each step end.
- Push 3,4,5 before the step -> src_addr 3,4,5 on the first three ACCUM cycles with src_valid=1, then IDLE_ADDR; FIFO empty afterwards.
- Push 10 addresses (FIFO_DEPTH=8) with in_valid held -> in_ready drops after 8 pushes; entries 0..7 are broadcast in the first ACCUM; entries 8,9 are accepted as the FIFO drains and broadcast next step.
- neuron_base=12'd0, neuron_spike=10'b0000010010 at the sampling cycle, out_ready=1 -> out_addr 1 then 4 on consecutive cycles, then the next clear.
- Same spike vector, out_ready=0 for 5 cycles -> out_valid=1, out_addr=1 held stable, no timestep advance until out_ready rises.
- Assert RESETN=0 during ACCUM with 4 entries queued -> next cycle outputs are at reset values, FIFO is empty, and a later enable starts from timestep 0.

Source files
------------

// File: rtl/spike_step_scheduler_if.sv
// Bus bundle between the timestep scheduler, its packet source, the neuron array and the NoC router.
// Handshakes (in_*, out_*): a beat transfers on a rising CLK edge where valid && ready are both 1;
// a valid source holds its payload stable until that edge and may not make valid depend on ready.
interface spike_step_scheduler_if #(
  parameter int NEURONS = 10,
  parameter int ADDR_W  = 12
);
  logic               in_valid;
  logic               in_ready;
  logic [ADDR_W-1:0]  in_addr;
  logic               src_valid;
  logic [ADDR_W-1:0]  src_addr;
  logic               clear;
  logic [NEURONS-1:0] neuron_spike;
  logic [ADDR_W-1:0]  neuron_base;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_addr;

  modport master (
    output in_ready, src_valid, src_addr, clear, out_valid, out_addr,
    input  in_valid, in_addr, neuron_spike, neuron_base, out_ready
  );

  modport slave (
    input  in_ready, src_valid, src_addr, clear, out_valid, out_addr,
    output in_valid, in_addr, neuron_spike, neuron_base, out_ready
  );
endinterface

// File: rtl/spike_step_scheduler.sv
// Timestep sequencer: buffers inbound spikes, broadcasts them during ACCUM, serialises fired neurons.
// Optional STEP_STATS_EN adds stat_spikes_out / stat_carry counters.
module spike_step_scheduler #(
  parameter int                NEURONS       = 10,
  parameter int                ADDR_W        = 12,
  parameter int                FIFO_DEPTH    = 8,
  parameter int                ACCUM_CYCLES  = 8,
  parameter int                SETTLE_CYCLES = 4,
  parameter logic [ADDR_W-1:0] IDLE_ADDR     = 12'hFFF
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        enable,
  spike_step_scheduler_if.master bus,
  output logic [15:0] timestep,
  output logic        busy,
  output logic [2:0]  state_dbg
`ifdef STEP_STATS_EN
  ,
  output logic [15:0] stat_spikes_out,
  output logic [7:0]  stat_carry
`endif
);
  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, SETTLE, EMIT} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int PH_W  = $clog2(ACCUM_CYCLES + SETTLE_CYCLES + 1);

  state_t             state, state_n;
  logic [PH_W-1:0]    phase, phase_n;
  logic [NEURONS-1:0] spike_reg, spike_n;
  logic [ADDR_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count, count_n;
  logic               push, pop, accept, step_end, load_emit;

  function automatic logic [IDX_W-1:0] lsb_idx(input logic [NEURONS-1:0] v);
    lsb_idx = '0;
    for (int i = NEURONS - 1; i >= 0; i--) begin
      if (v[i]) lsb_idx = IDX_W'(i);
    end
  endfunction

  assign state_dbg = state;
  assign push      = bus.in_valid && bus.in_ready;
  // Pops are timed to the edge entering each ACCUM cycle so src_addr is registered.
  assign pop       = (state_n == ACCUM) && (count != '0);
  assign load_emit = (state_n == EMIT) && ((state != EMIT) || accept);

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + (PTR_W+1)'(1);
    else if (!push && pop) count_n = count - (PTR_W+1)'(1);
  end

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    spike_n  = spike_reg;
    accept   = 1'b0;
    step_end = 1'b0;
    case (state)
      IDLE:  if (enable) state_n = CLEAR;
      CLEAR: begin
        state_n = ACCUM;
        phase_n = '0;
      end
      ACCUM: begin
        if (phase == PH_W'(ACCUM_CYCLES - 1)) begin
          state_n = SETTLE;
          phase_n = '0;
        end else begin
          phase_n = phase + PH_W'(1);
        end
      end
      SETTLE: begin
        if (phase == PH_W'(SETTLE_CYCLES - 1)) begin
          spike_n = bus.neuron_spike;
          phase_n = '0;
          if (bus.neuron_spike != '0) state_n = EMIT;
          else                        step_end = 1'b1;
        end else begin
          phase_n = phase + PH_W'(1);
        end
      end
      EMIT: begin
        if (bus.out_valid && bus.out_ready) begin
          accept  = 1'b1;
          spike_n = spike_reg & ~(NEURONS'(1) << lsb_idx(spike_reg));
          if (spike_n == '0) step_end = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (step_end) state_n = enable ? CLEAR : IDLE;
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.in_addr;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state         <= IDLE;
      phase         <= '0;
      spike_reg     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.in_ready  <= 1'b0;
      bus.src_valid <= 1'b0;
      bus.src_addr  <= IDLE_ADDR;
      bus.clear     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_addr  <= '0;
      timestep      <= '0;
      busy          <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      spike_reg <= spike_n;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count         <= count_n;
      bus.in_ready  <= (count_n != (PTR_W+1)'(FIFO_DEPTH));
      bus.src_valid <= pop;
      bus.src_addr  <= pop ? mem[rd_ptr] : IDLE_ADDR;
      bus.clear     <= (state_n == CLEAR);
      bus.out_valid <= (state_n == EMIT);
      // Address only changes when a new bit is presented, so it holds while the router stalls.
      if (load_emit) bus.out_addr <= bus.neuron_base + ADDR_W'(lsb_idx(spike_n));
      if (step_end)  timestep <= timestep + 16'd1;
      busy <= (state_n != IDLE);
    end
  end

`ifdef STEP_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      stat_spikes_out <= '0;
      stat_carry      <= '0;
    end else begin
      if (accept && (stat_spikes_out != 16'hFFFF)) stat_spikes_out <= stat_spikes_out + 16'd1;
      if ((state == ACCUM) && (state_n == SETTLE))  stat_carry <= 8'(count_n);
    end
  end
`endif
endmodule

// File: tb/tb_spike_step_scheduler.sv
// Self-checking bench for spike_step_scheduler: step-position reference model plus directed tables.
module tb_spike_step_scheduler;
  localparam int N     = 10;
  localparam int AW    = 12;
  localparam int DEPTH = 8;
  localparam int A     = 8;
  localparam int S     = 4;

  logic        CLK;
  logic        RESETN;
  logic        enable;
  logic [15:0] timestep;
  logic        busy;
  logic [2:0]  state_dbg;
`ifdef STEP_STATS_EN
  logic [15:0] stat_spikes_out;
  logic [7:0]  stat_carry;
`endif

  spike_step_scheduler_if #(.NEURONS(N), .ADDR_W(AW)) bus ();

  spike_step_scheduler dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .enable    (enable),
    .bus       (bus),
    .timestep  (timestep),
    .busy      (busy),
    .state_dbg (state_dbg)
`ifdef STEP_STATS_EN
    ,
    .stat_spikes_out (stat_spikes_out),
    .stat_carry      (stat_carry)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: inbound FIFO, pending outbound packets, position k within the step
  // (k=0 clear, 1..A broadcast window, A+1..A+S settle, beyond that emitting).
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_out_q[$];
  bit            m_idle = 1'b1;
  int            m_k = 0;
  logic          m_ready = 1'b0, m_src_valid = 1'b0, m_clear = 1'b0, m_out_valid = 1'b0, m_busy = 1'b0;
  logic [AW-1:0] m_src_addr = 12'hFFF, m_out_addr = '0;
  logic [15:0]   m_ts = '0;
  bit            last_push;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_out_q.delete();
    m_idle = 1'b1; m_k = 0; m_ready = 1'b0; m_src_valid = 1'b0; m_src_addr = 12'hFFF;
    m_clear = 1'b0; m_out_valid = 1'b0; m_out_addr = '0; m_ts = '0; m_busy = 1'b0;
  endtask

  task automatic model_step(input bit push, input bit acc, input logic [AW-1:0] pa,
                            input logic [N-1:0] spk, input logic [AW-1:0] base, input bit en);
    int nk = m_k;
    bit nidle = m_idle;
    bit fin = 1'b0;
    if (m_idle) begin
      if (en) begin nidle = 1'b0; nk = 0; end
    end else if (m_k < A + S) begin
      nk = m_k + 1;
    end else if (m_k == A + S) begin
      for (int i = 0; i < N; i++) if (spk[i]) exp_out_q.push_back(base + AW'(i));
      if (exp_out_q.size() == 0) fin = 1'b1;
      else nk = A + S + 1;
    end else begin
      if (acc) void'(exp_out_q.pop_front());
      if (exp_out_q.size() == 0) fin = 1'b1;
    end
    if (fin) begin
      m_ts = m_ts + 16'd1;
      if (en) nk = 0;
      else    nidle = 1'b1;
    end
    if (!nidle && nk >= 1 && nk <= A && exp_q.size() > 0) begin
      m_src_addr  = exp_q.pop_front();
      m_src_valid = 1'b1;
    end else begin
      m_src_addr  = 12'hFFF;
      m_src_valid = 1'b0;
    end
    if (push) exp_q.push_back(pa);
    m_ready     = (exp_q.size() < DEPTH);
    m_clear     = !nidle && (nk == 0);
    m_out_valid = !nidle && (nk > A + S);
    if (m_out_valid) m_out_addr = exp_out_q[0];
    m_busy = !nidle;
    m_idle = nidle;
    m_k    = nk;
  endtask

  // One clock: inputs already driven; update model at the edge, compare #1 later.
  task automatic cyc();
    bit push, acc;
    logic [AW-1:0] pa;
    logic [N-1:0]  spk;
    logic [AW-1:0] base;
    bit en, rst_n;
    push = bus.in_valid && m_ready;
    acc  = m_out_valid && bus.out_ready;
    pa = bus.in_addr; spk = bus.neuron_spike; base = bus.neuron_base; en = enable; rst_n = RESETN;
    @(posedge CLK);
    last_push = push && rst_n;
    if (!rst_n) model_reset();
    else        model_step(push, acc, pa, spk, base, en);
    #1;
    chk("in_ready",  bus.in_ready,  m_ready);
    chk("clear",     bus.clear,     m_clear);
    chk("src_valid", bus.src_valid, m_src_valid);
    chk("src_addr",  bus.src_addr,  m_src_addr);
    chk("out_valid", bus.out_valid, m_out_valid);
    chk("out_addr",  bus.out_addr,  m_out_addr);
    chk("timestep",  timestep,      m_ts);
    chk("busy",      busy,          m_busy);
  endtask

  task automatic wait_clear(input int limit);
    int n = 0;
    do begin cyc(); n++; end while (!bus.clear && n < limit);
    chk("wait_clear_bound", bus.clear, 1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin cyc(); n++; end
    chk("wait_idle_bound", busy, 0);
  endtask

  typedef struct {
    logic [N-1:0]  vec;
    logic [AW-1:0] base;
    int            n;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
  } emit_vec_t;

  emit_vec_t tbl[5];

  initial begin
    int clr_at[3];
    int ci, nacc, nsrc, nout, ts_hold;
    logic [AW-1:0] first_a, last_a;
    bit done;
    logic [AW-1:0] exp_src[4];
    logic          exp_sv[4];

    tbl[0] = '{vec: 10'b0000010010, base: 12'd0,   n: 2,  first: 12'd1,   last: 12'd4};
    tbl[1] = '{vec: 10'b1000000001, base: 12'hFFE, n: 2,  first: 12'hFFE, last: 12'h007};
    tbl[2] = '{vec: 10'h3FF,        base: 12'd100, n: 10, first: 12'd100, last: 12'd109};
    tbl[3] = '{vec: 10'h000,        base: 12'd50,  n: 0,  first: 12'd0,   last: 12'd0};
    tbl[4] = '{vec: 10'b1000000000, base: 12'd5,   n: 1,  first: 12'd14,  last: 12'd14};
    exp_src[0] = 12'd3; exp_src[1] = 12'd4; exp_src[2] = 12'd5; exp_src[3] = 12'hFFF;
    exp_sv[0] = 1'b1; exp_sv[1] = 1'b1; exp_sv[2] = 1'b1; exp_sv[3] = 1'b0;

    RESETN = 1'b0; enable = 1'b0;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.out_ready = 1'b1;
    bus.neuron_spike = '0; bus.neuron_base = '0;

    // Reset values
    repeat (3) cyc();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_src_valid", bus.src_valid, 0);
    chk("rst_src_addr", bus.src_addr, 12'hFFF);
    chk("rst_clear", bus.clear, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_timestep", timestep, 0);
    chk("rst_busy", busy, 0);
    RESETN = 1'b1;
    repeat (2) cyc();

    // Clear period with no traffic
    clr_at[0] = -1; clr_at[1] = -1; clr_at[2] = -1;
    ci = 0;
    enable = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      cyc();
      if (bus.clear && ci < 3) begin clr_at[ci] = c; ci++; end
    end
    chk("clear_cycle_0", clr_at[0], 1);
    chk("clear_cycle_1", clr_at[1], 14);
    chk("clear_cycle_2", clr_at[2], 27);
    enable = 1'b0;
    wait_idle(40);

    // Three queued addresses broadcast in order, then idle address
    bus.in_valid = 1'b1;
    for (int a = 3; a <= 5; a++) begin bus.in_addr = AW'(a); cyc(); end
    bus.in_valid = 1'b0;
    enable = 1'b1;
    wait_clear(5);
    for (int j = 0; j < 4; j++) begin
      cyc();
      chk("bcast_valid", bus.src_valid, exp_sv[j]);
      chk("bcast_addr", bus.src_addr, exp_src[j]);
    end
    enable = 1'b0;
    wait_idle(30);

    // Overfill: 10 addresses with in_valid held
    nacc = 0;
    bus.in_valid = 1'b1; bus.in_addr = 12'd100;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (last_push) nacc++;
      bus.in_addr = AW'(100 + nacc);
    end
    chk("full_accepts", nacc, 8);
    chk("full_in_ready", bus.in_ready, 0);
    enable = 1'b1;
    nsrc = 0;
    for (int c = 0; c < 30; c++) begin
      cyc();
      if (last_push) nacc++;
      if (nacc >= 10) bus.in_valid = 1'b0;
      else bus.in_addr = AW'(100 + nacc);
      if (bus.src_valid) nsrc++;
    end
    chk("overfill_total_accepts", nacc, 10);
    chk("overfill_broadcasts", nsrc, 10);

    // Emission table
    wait_clear(20);
    for (int r = 0; r < 5; r++) begin
      bus.neuron_base = tbl[r].base;
      bus.neuron_spike = tbl[r].vec;
      nout = 0; done = 1'b0; first_a = '0; last_a = '0;
      for (int c = 0; c < 40 && !done; c++) begin
        cyc();
        if (bus.out_valid && bus.out_ready) begin
          if (nout == 0) first_a = bus.out_addr;
          last_a = bus.out_addr;
          nout++;
        end
        if (bus.clear) done = 1'b1;
      end
      chk("emit_step_done", done, 1);
      chk("emit_count", nout, tbl[r].n);
      if (tbl[r].n > 0) begin
        chk("emit_first", first_a, tbl[r].first);
        chk("emit_last", last_a, tbl[r].last);
      end
    end

    // Router stall holds the first packet and the timestep
    bus.neuron_base = 12'd0; bus.neuron_spike = 10'b0000010010; bus.out_ready = 1'b0;
    for (int c = 0; c < 20 && !bus.out_valid; c++) cyc();
    chk("stall_out_valid", bus.out_valid, 1);
    ts_hold = int'(m_ts);
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("stall_valid_held", bus.out_valid, 1);
      chk("stall_addr_held", bus.out_addr, 12'd1);
      chk("stall_ts_held", timestep, ts_hold);
    end
    bus.out_ready = 1'b1;
    cyc();
    chk("stall_second_addr", bus.out_addr, 12'd4);
    cyc();
    chk("stall_next_clear", bus.clear, 1);
    chk("stall_ts_advance", timestep, ts_hold + 1);
    bus.neuron_spike = '0;

    // Randomised traffic against the model
    bus.neuron_base = AW'($urandom_range(0, 4095));
    for (int c = 0; c < 400; c++) begin
      bus.in_valid     = $urandom_range(0, 1);
      bus.in_addr      = AW'($urandom_range(0, 4095));
      bus.out_ready    = ($urandom_range(0, 3) != 0);
      bus.neuron_spike = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom_range(0, 1023));
      enable           = ($urandom_range(0, 31) != 0);
      cyc();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.neuron_spike = '0; enable = 1'b0;
    wait_idle(60);

    // Reset during ACCUM with entries still queued
    bus.in_valid = 1'b1;
    for (int a = 0; a < 8; a++) begin bus.in_addr = AW'(200 + a); cyc(); end
    bus.in_valid = 1'b0;
    enable = 1'b1;
    wait_clear(5);
    repeat (4) cyc();
    chk("pre_rst_queued", exp_q.size(), 4);
    RESETN = 1'b0;
    cyc();
    chk("mid_rst_src_valid", bus.src_valid, 0);
    chk("mid_rst_src_addr", bus.src_addr, 12'hFFF);
    chk("mid_rst_clear", bus.clear, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_timestep", timestep, 0);
    chk("mid_rst_busy", busy, 0);
    RESETN = 1'b1;
    wait_clear(5);
    chk("post_rst_timestep", timestep, 0);
    nsrc = 0;
    for (int c = 0; c < A; c++) begin
      cyc();
      if (bus.src_valid) nsrc++;
    end
    chk("post_rst_fifo_empty", nsrc, 0);
    enable = 1'b0;
    wait_idle(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
